trig_capture: RTL and testbench
===============================

TRIG_CAPTURE -- requirements
Module: trig_capture

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16, meaning sample width.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, meaning capture address width; DEPTH = 2**ADDR_SIZE.
REQ-003 The block SHALL have one clock and a synchronous active-high reset, listed first: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 The block SHALL have these inputs: arm in 1, start acquisition pulse; sample in DATA_SIZE, filtered sample (filter result); sample_valid in 1, one-cycle strobe (filter done).
REQ-005 The block SHALL have these trigger-control inputs: trig_level in DATA_SIZE, unsigned threshold; trig_edge in 1, 0=rising 1=falling; trig_force in 1, force-trigger request; pretrig in ADDR_SIZE, pre-trigger sample count.
REQ-006 The block SHALL have these readout signals: rd_en in 1, read request; rd_data out DATA_SIZE, readout sample; rd_valid out 1, rd_data qualifier.
REQ-007 The block SHALL have these status outputs: busy out 1, acquisition in progress; capture_done out 1, buffer full and readable; trig_seen out 1, trigger occurred.

Function
REQ-008 States SHALL be IDLE, PRE, WAIT_TRIG, POST, DONE, READ.
REQ-009 arm SHALL be accepted only in IDLE or DONE, moving to PRE and clearing write pointer, counters, trig_seen and prev_valid; arm in any other state SHALL be ignored.
REQ-010 A sample_valid in the same cycle as an accepted arm SHALL NOT be captured.
REQ-011 In PRE, WAIT_TRIG and POST, each sample_valid SHALL write sample at wr_ptr into a DEPTH-entry circular buffer and increment wr_ptr modulo DEPTH.
REQ-012 PRE SHALL move to WAIT_TRIG after min(pretrig, DEPTH-1) samples are written; with pretrig=0 the transition SHALL occur on the cycle after arm.
REQ-013 Rising trigger SHALL be prev_valid and prev < trig_level and sample >= trig_level; falling trigger SHALL be prev_valid and prev > trig_level and sample <= trig_level; comparisons SHALL be unsigned.
REQ-014 prev SHALL update on every captured sample_valid; prev_valid SHALL set after the first captured sample.
REQ-015 A trig_force pulse in WAIT_TRIG SHALL latch a request that makes the next sample_valid the trigger sample regardless of level.
REQ-016 WAIT_TRIG SHALL write and wrap freely; triggers SHALL NOT be evaluated in PRE.
REQ-017 The trigger sample SHALL be written, trig_seen SHALL set, start_addr SHALL be set to (trigger addr - pretrig_eff) mod DEPTH, and the state SHALL go to POST.
REQ-018 POST SHALL capture DEPTH-1-pretrig_eff further samples, then go to DONE.
REQ-019 If that count is zero, the state SHALL go to DONE on the cycle after the trigger.
REQ-020 busy SHALL be 1 in PRE, WAIT_TRIG and POST.
REQ-021 capture_done SHALL be 1 in DONE and READ.
REQ-022 In DONE or READ, each rd_en SHALL read buffer[rd_ptr], with rd_ptr starting at start_addr and incrementing modulo DEPTH.
REQ-023 rd_data and rd_valid SHALL be registered and appear 1 cycle after rd_en.
REQ-024 The first rd_en SHALL move DONE to READ; after the DEPTH-th read the state SHALL go to IDLE, and further rd_en SHALL be ignored, with rd_valid=0.
REQ-025 rd_en outside DONE or READ SHALL be ignored.
REQ-026 rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-027 rst SHALL force IDLE in any state, including mid-capture or mid-read.
REQ-028 On rst, rd_data SHALL be 0, rd_valid 0, busy 0, capture_done 0 and trig_seen 0, and all pointers, counters, prev, prev_valid and force request SHALL be 0.
REQ-029 Buffer contents SHALL NOT require reset.

Structure
REQ-030 A shared package SHALL hold the state enumeration and the FSM constants TRIG_RISING=0 and TRIG_FALLING=1.
REQ-031 The buffer SHALL be one sub-module, capture_ram: single-clock simple dual-port, synchronous read, DATA_SIZE x DEPTH.
REQ-032 FSM, trigger compare and pointers SHALL live in trig_capture.

Verification
REQ-033 With ADDR_SIZE=4, pretrig=4, rising, level=100 and a ramp 0,10,...,250 one sample per 3 clks: trigger SHALL occur at sample 100, and readout SHALL give 60,70,80,90,100,...,210 (16 words).
REQ-034 With falling, level=50, a ramp down 200..0 step 10 and pretrig=0: the first read word SHALL be 50, with trig_seen=1.
REQ-035 With a constant input of 5 and level=100, trig_force pulsed in WAIT_TRIG: capture SHALL complete, 16 words of 5 SHALL be read, and the state SHALL return to IDLE.
REQ-036 With pretrig=15 and a trigger: DONE SHALL follow the trigger by 1 cycle, and the last read word SHALL equal the trigger sample.
REQ-037 With rst asserted in POST, then in READ: all outputs SHALL be 0 next cycle, and a subsequent arm SHALL run a fresh, correct capture.
REQ-038 With arm during WAIT_TRIG, rd_en during POST, and sample_valid coincident with arm: the first two SHALL be ignored, and the coincident sample SHALL NOT appear in the buffer.

Source files
------------

// File: rtl/trig_capture_pkg.sv
// rtl/trig_capture_pkg.sv - shared state encoding and trigger-edge constants for trig_capture
package trig_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_DONE,
    S_READ
  } state_t;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

endpackage

// File: rtl/trig_capture_ram.sv
// rtl/trig_capture_ram.sv - capture_ram: DATA_SIZE x 2**ADDR_SIZE simple dual-port buffer, synchronous read
// clk          : single clock for both ports
// we/waddr/wdata : write port
// re/raddr     : read request and address
// rdata        : registered read data, updates only when re is high
module capture_ram #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  // No reset on storage or the read register; the top masks rdata until a read has happened.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trig_capture.sv
// rtl/trig_capture.sv - triggered sample capture with pre-trigger history and sequential readout
// clk, rst          : rising-edge clock, synchronous active-high reset
// arm               : start acquisition (accepted in IDLE or DONE)
// sample/sample_valid : incoming filtered sample and its strobe
// trig_level/trig_edge/trig_force/pretrig : trigger threshold, edge select, forced trigger, history length
// rd_en -> rd_data/rd_valid : readout request, data one cycle later
// busy/capture_done/trig_seen : acquisition status
module trig_capture
  import trig_capture_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [DATA_SIZE-1:0] sample,
  input  logic                 sample_valid,
  input  logic [DATA_SIZE-1:0] trig_level,
  input  logic                 trig_edge,
  input  logic                 trig_force,
  input  logic [ADDR_SIZE-1:0] pretrig,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 capture_done,
  output logic                 trig_seen
);

  state_t state_q, state_d;

  logic [ADDR_SIZE-1:0] wr_ptr_q;
  logic [ADDR_SIZE-1:0] cnt_q;
  logic [ADDR_SIZE-1:0] pre_eff_q;
  logic [ADDR_SIZE-1:0] rd_ptr_q;
  logic [ADDR_SIZE-1:0] rd_cnt_q;
  logic [DATA_SIZE-1:0] prev_q;
  logic                 prev_valid_q;
  logic                 force_q;
  logic                 trig_seen_q;
  logic                 rd_valid_q;
  logic                 data_ok_q;
  logic [DATA_SIZE-1:0] ram_rdata;

  logic                 arm_ok;
  logic                 rd_ok;
  logic                 capturing;
  logic                 rise_hit;
  logic                 fall_hit;
  logic                 trig_now;
  logic [ADDR_SIZE-1:0] post_len;

  assign arm_ok    = arm && (state_q == S_IDLE || state_q == S_DONE);
  assign rd_ok     = rd_en && !arm_ok && (state_q == S_DONE || state_q == S_READ);
  assign capturing = sample_valid &&
                     (state_q == S_PRE || state_q == S_WAIT_TRIG || state_q == S_POST);

  assign rise_hit = prev_valid_q && (prev_q < trig_level) && (sample >= trig_level);
  assign fall_hit = prev_valid_q && (prev_q > trig_level) && (sample <= trig_level);
  assign trig_now = (state_q == S_WAIT_TRIG) && sample_valid &&
                    (force_q || ((trig_edge == TRIG_FALLING) ? fall_hit : rise_hit));

  // Samples still to capture after the trigger so the buffer ends exactly full.
  assign post_len = {ADDR_SIZE{1'b1}} - pre_eff_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (arm_ok) state_d = S_PRE;
      S_PRE: begin
        if (pre_eff_q == '0) state_d = S_WAIT_TRIG;
        else if (sample_valid && cnt_q == pre_eff_q - ADDR_SIZE'(1)) state_d = S_WAIT_TRIG;
      end
      S_WAIT_TRIG: if (trig_now) state_d = (post_len == '0) ? S_DONE : S_POST;
      S_POST:      if (sample_valid && cnt_q == ADDR_SIZE'(1)) state_d = S_DONE;
      S_DONE: begin
        if (arm_ok)     state_d = S_PRE;
        else if (rd_ok) state_d = S_READ;
      end
      S_READ:      if (rd_ok && rd_cnt_q == {ADDR_SIZE{1'b1}}) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pre_eff_q    <= '0;
      rd_ptr_q     <= '0;
      rd_cnt_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      force_q      <= 1'b0;
      trig_seen_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_ok;
      if (rd_ok) data_ok_q <= 1'b1;

      if (arm_ok) begin
        wr_ptr_q     <= '0;
        cnt_q        <= '0;
        rd_cnt_q     <= '0;
        prev_valid_q <= 1'b0;
        force_q      <= 1'b0;
        trig_seen_q  <= 1'b0;
        // pretrig is ADDR_SIZE wide, so it can never exceed DEPTH-1.
        pre_eff_q    <= pretrig;
      end else begin
        if (capturing) begin
          wr_ptr_q     <= wr_ptr_q + ADDR_SIZE'(1);
          prev_q       <= sample;
          prev_valid_q <= 1'b1;
        end

        if (state_q == S_PRE && sample_valid) cnt_q <= cnt_q + ADDR_SIZE'(1);

        if (state_q == S_WAIT_TRIG) begin
          if (trig_force) force_q <= 1'b1;
          if (trig_now) begin
            trig_seen_q <= 1'b1;
            force_q     <= 1'b0;
            rd_ptr_q    <= wr_ptr_q - pre_eff_q;
            cnt_q       <= post_len;
          end
        end

        if (state_q == S_POST && sample_valid) cnt_q <= cnt_q - ADDR_SIZE'(1);

        if (rd_ok) begin
          rd_ptr_q <= rd_ptr_q + ADDR_SIZE'(1);
          rd_cnt_q <= rd_cnt_q + ADDR_SIZE'(1);
        end
      end
    end
  end

  capture_ram #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (capturing && !arm_ok),
    .waddr (wr_ptr_q),
    .wdata (sample),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; show zero until the first read since reset.
  assign rd_data      = data_ok_q ? ram_rdata : '0;
  assign rd_valid     = rd_valid_q;
  assign busy         = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
  assign capture_done = (state_q == S_DONE) || (state_q == S_READ);
  assign trig_seen    = trig_seen_q;

endmodule

// File: tb/tb_trig_capture.sv
// tb/tb_trig_capture.sv - directed self-checking bench for trig_capture
module tb_trig_capture;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic [DW-1:0] trig_level;
  logic          trig_edge;
  logic          trig_force;
  logic [AW-1:0] pretrig;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          capture_done;
  logic          trig_seen;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] got   [DEPTH];
  logic          got_v [DEPTH];
  logic          post_v;
  logic [DW-1:0] post_d;

  trig_capture #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .sample       (sample),
    .sample_valid (sample_valid),
    .trig_level   (trig_level),
    .trig_edge    (trig_edge),
    .trig_force   (trig_force),
    .pretrig      (pretrig),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .capture_done (capture_done),
    .trig_seen    (trig_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within 300000 ns");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int pre, input logic edge_sel, input int level);
    pretrig    = AW'(pre);
    trig_edge  = edge_sel;
    trig_level = DW'(level);
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic feed_one(input int v);
    sample       = DW'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_ramp(input int last);
    do_arm(4, 1'b0, 100);
    for (int v = 0; v <= last; v += 10) feed_one(v);
  endtask

  task automatic read_all();
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      got[i]   = rd_data;
      got_v[i] = rd_valid;
    end
    rd_en = 1'b0;
    tick();
    post_v = rd_valid;
    post_d = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; sample = '0; sample_valid = 1'b0; trig_level = '0;
    trig_edge = 1'b0; trig_force = 1'b0; pretrig = '0; rd_en = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", capture_done); end
    n_checks++; if (trig_seen !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", trig_seen); end
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin n_fail++; $display("FAIL reset_rd: got valid %b data %0d want 0/0", rd_valid, rd_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rising();
    do_arm(4, 1'b0, 100);
    for (int v = 0; v <= 250; v += 10) begin
      feed_one(v);
      if (v == 90) begin
        n_checks++; if (trig_seen !== 1'b0) begin n_fail++; $display("FAIL rising_early_trig: got %b want 0", trig_seen); end
      end
      if (v == 100) begin
        n_checks++; if (trig_seen !== 1'b1) begin n_fail++; $display("FAIL rising_trig_at_100: got %b want 1", trig_seen); end
      end
    end
    n_checks++; if (capture_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rising_done: got done %b busy %b want 1/0", capture_done, busy); end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (got_v[i] !== 1'b1 || got[i] !== DW'(60 + 10 * i)) begin
        n_fail++; $display("FAIL rising_word%0d: got %0d valid %b want %0d", i, got[i], got_v[i], 60 + 10 * i);
      end
    end
    n_checks++; if (post_v !== 1'b0 || post_d !== DW'(210)) begin n_fail++; $display("FAIL rising_hold: got valid %b data %0d want 0/210", post_v, post_d); end
    n_checks++; if (capture_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rising_idle: got done %b busy %b want 0/0", capture_done, busy); end
  endtask

  task automatic test_falling();
    int exp;
    do_arm(0, 1'b1, 50);
    for (int v = 200; v >= 0; v -= 10) feed_one(v);
    for (int k = 0; k < 10; k++) feed_one(0);
    n_checks++; if (capture_done !== 1'b1 || trig_seen !== 1'b1) begin n_fail++; $display("FAIL falling_done: got done %b trig %b want 1/1", capture_done, trig_seen); end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i <= 5) ? 50 - 10 * i : 0;
      n_checks++;
      if (got_v[i] !== 1'b1 || got[i] !== DW'(exp)) begin
        n_fail++; $display("FAIL falling_word%0d: got %0d valid %b want %0d", i, got[i], got_v[i], exp);
      end
    end
  endtask

  task automatic test_force();
    do_arm(4, 1'b0, 100);
    for (int k = 0; k < 6; k++) feed_one(5);
    n_checks++; if (trig_seen !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL force_pre: got trig %b busy %b want 0/1", trig_seen, busy); end
    trig_force = 1'b1;
    tick();
    trig_force = 1'b0;
    for (int k = 0; k < 12; k++) begin
      feed_one(5);
      if (k == 10) begin
        n_checks++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL force_done_early: got %b want 0", capture_done); end
      end
    end
    n_checks++; if (capture_done !== 1'b1 || trig_seen !== 1'b1) begin n_fail++; $display("FAIL force_done: got done %b trig %b want 1/1", capture_done, trig_seen); end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (got_v[i] !== 1'b1 || got[i] !== DW'(5)) begin
        n_fail++; $display("FAIL force_word%0d: got %0d valid %b want 5", i, got[i], got_v[i]);
      end
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b0 || capture_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL force_idle: got valid %b done %b busy %b want 0/0/0", rd_valid, capture_done, busy); end
  endtask

  task automatic test_pretrig_max();
    int exp;
    do_arm(15, 1'b0, 100);
    for (int v = 1; v <= 15; v++) feed_one(v);
    n_checks++; if (capture_done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL pre15_before: got done %b busy %b want 0/1", capture_done, busy); end
    sample       = DW'(200);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    n_checks++; if (capture_done !== 1'b1 || trig_seen !== 1'b1) begin n_fail++; $display("FAIL pre15_done_next: got done %b trig %b want 1/1", capture_done, trig_seen); end
    tick();
    tick();
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < 15) ? i + 1 : 200;
      n_checks++;
      if (got_v[i] !== 1'b1 || got[i] !== DW'(exp)) begin
        n_fail++; $display("FAIL pre15_word%0d: got %0d valid %b want %0d", i, got[i], got_v[i], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_ramp(120);
    n_checks++; if (busy !== 1'b1 || trig_seen !== 1'b1) begin n_fail++; $display("FAIL post_state: got busy %b trig %b want 1/1", busy, trig_seen); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || capture_done !== 1'b0 || trig_seen !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++; $display("FAIL rst_in_post: got busy %b done %b trig %b valid %b data %0d want all 0", busy, capture_done, trig_seen, rd_valid, rd_data);
    end
    run_ramp(250);
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(60 + 10 * i)) begin
        n_fail++; $display("FAIL partial_word%0d: got %0d valid %b want %0d", i, rd_data, rd_valid, 60 + 10 * i);
      end
    end
    rd_en = 1'b0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || capture_done !== 1'b0 || trig_seen !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++; $display("FAIL rst_in_read: got busy %b done %b trig %b valid %b data %0d want all 0", busy, capture_done, trig_seen, rd_valid, rd_data);
    end
    run_ramp(250);
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (got_v[i] !== 1'b1 || got[i] !== DW'(60 + 10 * i)) begin
        n_fail++; $display("FAIL fresh_word%0d: got %0d valid %b want %0d", i, got[i], got_v[i], 60 + 10 * i);
      end
    end
  endtask

  task automatic test_ignored();
    int exp;
    // If the coincident 999 were captured it would arm prev, and 100 would falsely trigger.
    pretrig      = '0;
    trig_edge    = 1'b1;
    trig_level   = DW'(500);
    sample       = DW'(999);
    sample_valid = 1'b1;
    arm          = 1'b1;
    tick();
    arm          = 1'b0;
    sample_valid = 1'b0;
    tick();
    feed_one(100);
    n_checks++; if (trig_seen !== 1'b0) begin n_fail++; $display("FAIL coincident_sample: got trig %b want 0", trig_seen); end
    feed_one(600);
    // An accepted arm here would clear prev_valid and suppress the 600 -> 400 falling trigger.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    feed_one(400);
    n_checks++; if (trig_seen !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL arm_in_wait: got trig %b busy %b want 1/1", trig_seen, busy); end
    feed_one(300);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_in_post: got valid %b want 0", rd_valid); end
    for (int k = 1; k < 15; k++) feed_one(300 - 10 * k);
    n_checks++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL ignored_done: got %b want 1", capture_done); end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i == 0) ? 400 : 310 - 10 * i;
      n_checks++;
      if (got_v[i] !== 1'b1 || got[i] !== DW'(exp)) begin
        n_fail++; $display("FAIL ignored_word%0d: got %0d valid %b want %0d", i, got[i], got_v[i], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_force();
    test_pretrig_max();
    test_reset_mid();
    test_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
